// File: rtl/div_8bits.sv
// div_8bits: sequential restoring divider, 8-bit unsigned dividend by
// 4-bit unsigned divisor. One quotient bit is resolved per clock under a
// three-state controller with a start/busy/done handshake. A zero divisor
// short-circuits straight to the end state with all-ones results and div0_o.
module div_8bits (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] A_i,
    input  logic [3:0] B_i,
    output logic [7:0] Q_o,
    output logic [3:0] R_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       div0_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_END  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_d;        // dividend shifting out, quotient shifting in
    logic [3:0]  r_b;        // captured divisor
    logic [4:0]  r_p;        // partial remainder; bit 4 is always 0 between iterations
    logic [2:0]  r_cnt;      // iteration index, 0..7
    logic [7:0]  r_q;
    logic [3:0]  r_r;
    logic        r_div0;

    logic        w_start;
    logic        w_zero_div;
    logic        w_last;
    logic [5:0]  w_p_shift;
    logic [5:0]  w_diff;
    logic        w_borrow;
    logic [4:0]  w_p_next;
    logic [7:0]  w_d_next;

    assign w_start    = (r_state == ST_IDLE) && en_i;
    assign w_zero_div = (B_i == 4'd0);
    assign w_last     = (r_state == ST_CALC) && (r_cnt == 3'd7);

    // One restoring step: shift {P,D} left, trial-subtract the divisor from
    // the shifted remainder, keep the difference only if it did not borrow.
    // The shifted remainder carries r_p[4] as its top bit so the trial is
    // exact even if that bit were ever set; it is 0 in normal operation.
    assign w_p_shift  = {r_p, r_d[7]};
    assign w_diff     = w_p_shift - {2'b00, r_b};
    assign w_borrow   = w_diff[5];
    assign w_p_next   = w_borrow ? w_p_shift[4:0] : w_diff[4:0];
    assign w_d_next   = {r_d[6:0], ~w_borrow};

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start request only honoured in idle; a zero divisor
    // skips the iteration phase entirely.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = w_zero_div ? ST_END : ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_next_state = ST_END;
                end
            end
            ST_END:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            ST_CALC: busy_o = 1'b1;
            ST_END:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture operands on start, iterate in CALC, and update the
    // result registers only when entering END so they hold between operations.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_d    <= 8'd0;
            r_b    <= 4'd0;
            r_p    <= 5'd0;
            r_cnt  <= 3'd0;
            r_q    <= 8'd0;
            r_r    <= 4'd0;
            r_div0 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_zero_div) begin
                        r_d   <= A_i;
                        r_b   <= B_i;
                        r_p   <= 5'd0;
                        r_cnt <= 3'd0;
                    end else if (w_start) begin
                        r_q    <= 8'hFF;
                        r_r    <= 4'hF;
                        r_div0 <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_p   <= w_p_next;
                    r_d   <= w_d_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_q    <= w_d_next;
                        r_r    <= w_p_next[3:0];
                        r_div0 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q_o    = r_q;
    assign R_o    = r_r;
    assign div0_o = r_div0;

endmodule

// File: tb/tb_div_8bits.sv
// Testbench for div_8bits. Stimulus issues divides and pushes the expected
// result into a scoreboard queue; an independent monitor pops and compares
// each time done_o is seen. Expected values come from plain integer / and %.
module tb_div_8bits;

    logic       clk_i;
    logic       rst_i;
    logic       en_i;
    logic [7:0] A_i;
    logic [3:0] B_i;
    logic [7:0] Q_o;
    logic [3:0] R_o;
    logic       busy_o;
    logic       done_o;
    logic       div0_o;

    div_8bits dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .A_i    (A_i),
        .B_i    (B_i),
        .Q_o    (Q_o),
        .R_o    (R_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .div0_o (div0_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int div0;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: arithmetic division, with the all-ones convention for /0.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = 255; e.r = 15; e.div0 = 1; e.busy = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.div0 = 0; e.busy = 8;
        end
        return e;
    endfunction

    // Monitor: compare every done_o against the head of the scoreboard.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            busy_cnt = 0;
        end else begin
            if (busy_o && done_o) check("busy_and_done_overlap", 1, 0);
            if (busy_o) busy_cnt++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", int'(Q_o), e.q);
                    check("remainder", int'(R_o), e.r);
                    check("div0", int'(div0_o), e.div0);
                    check("busy_cycles", busy_cnt, e.busy);
                    if (e.b != 0) begin
                        check("inv_a_eq_qb_plus_r", int'(Q_o) * e.b + int'(R_o), e.a);
                        check("inv_r_lt_b", int'(int'(R_o) < e.b), 1);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    // Wait for done_o, counting negedges; an expired budget is a failure.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk_i);
            n++;
            if (done_o) return;
        end
        check("done_timeout", 0, 1);
    endtask

    // Issue one divide from idle and check its start-to-done latency.
    task automatic do_op(input int a, input int b);
        int n;
        @(posedge clk_i); #1;
        A_i = 8'(a); B_i = 4'(b); en_i = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk_i); #1;
        en_i = 1'b0;
        A_i = 8'($urandom); B_i = 4'($urandom);
        wait_done(30, n);
        check("latency", n, (b == 0) ? 1 : 9);
    endtask

    initial begin
        int n;
        int dones;
        rst_i = 1'b1; en_i = 1'b0; A_i = 8'd0; B_i = 4'd0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state held through idle cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("idle_outputs", int'({Q_o, R_o, busy_o, done_o, div0_o}), 0);
        end

        // Directed normal and boundary divides.
        do_op(200, 7);
        do_op(255, 15);
        do_op(5, 9);
        do_op(0, 1);
        do_op(255, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("result_hold", int'({Q_o, R_o, div0_o}), int'({8'd255, 4'd0, 1'b0}));
        end

        // Divide by zero, then a normal divide clears div0_o.
        do_op(13, 0);
        do_op(100, 10);

        // en_i pulse with new operands during CALC is ignored.
        @(posedge clk_i); #1;
        A_i = 8'd200; B_i = 4'd7; en_i = 1'b1;
        sb.push_back(model(200, 7));
        @(posedge clk_i); #1; en_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; A_i = 8'd9; B_i = 4'd3; en_i = 1'b1;
        @(posedge clk_i); #1; en_i = 1'b0;
        wait_done(30, n);
        check("latency_after_ignored_en", n, 6);

        // en_i held high restarts every 10 cycles.
        @(posedge clk_i); #1;
        A_i = 8'd100; B_i = 4'd7; en_i = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(model(100, 7));
        @(posedge clk_i); #1;
        wait_done(30, n);
        check("held_first_latency", n, 9);
        for (int k = 0; k < 2; k++) begin
            wait_done(30, n);
            check("held_done_period", n, 10);
        end
        @(posedge clk_i); #1; en_i = 1'b0;

        // Reset at edge 4 of an operation aborts it with no done_o.
        @(posedge clk_i); #1;
        A_i = 8'd200; B_i = 4'd7; en_i = 1'b1;
        @(posedge clk_i); #1; en_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; rst_i = 1'b1;
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_outputs", int'({Q_o, R_o, busy_o, done_o, div0_o}), 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        check("abort_no_done", dones, 0);
        do_op(50, 6);

        // Exhaustive operand sweep.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(a, b);
            end
        end

        // Random operands.
        for (int i = 0; i < 100; i++) begin
            do_op(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)));
        end

        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_8bits.md
# div_8bits

Sequential shift-subtract (restoring) divider: divides an unsigned 8-bit dividend by an unsigned 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder. It is the inverse companion of the team's 4-bit shift-add multiplier and uses the same single-clock, register-plus-controller datapath style. It resolves one quotient bit per cycle under a small controller FSM, with a start/busy/done handshake.

## Interface
Parameters:
- none. Widths are fixed: dividend 8, divisor 4, quotient 8, remainder 4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- en_i  in  1  start request; sampled only in ST_IDLE.
- A_i  in  8  dividend, unsigned; captured on start edge.
- B_i  in  4  divisor, unsigned; captured on start edge.
- Q_o  out  8  quotient; registered.
- R_o  out  4  remainder; registered.
- busy_o  out  1  high while in ST_CALC.
- done_o  out  1  high for exactly one cycle in ST_END.
- div0_o  out  1  divide-by-zero flag for the last operation; registered.

## Operation
- FSM states: ST_IDLE, ST_CALC, ST_END.
- ST_IDLE, en_i=1, B_i!=0 -> ST_CALC. Load dividend shift register with A_i, divisor register with B_i, 5-bit partial remainder with 0, iteration counter with 0.
- ST_IDLE, en_i=1, B_i==0 -> ST_END directly. Q_o=8'hFF, R_o=4'hF, div0_o=1.
- ST_IDLE, en_i=0 -> stay in ST_IDLE. All outputs hold.
- ST_CALC iteration, once per cycle:
  - {P,D} shifted left by 1, where P is the 5-bit partial remainder and D is the dividend/quotient register.
  - T = P_shifted - {1'b0,divisor}, computed 5 bits wide with borrow.
  - No borrow: P = T and D[0] = 1.
  - Borrow: P is kept and D[0] = 0.
  - Counter increments.
- After the 8th iteration -> ST_END. Q_o = D, R_o = P[3:0], div0_o = 0.
- ST_END -> ST_IDLE unconditionally. en_i is ignored in ST_END.
- en_i is ignored while in ST_CALC. In-flight operands are never disturbed.
- Q_o, R_o and div0_o change only on entry to ST_END or on reset. They hold between operations.
- Invariants for every non-zero divisor:
  - A_i == Q_o*B_i + R_o
  - R_o < B_i
  - P[4] is always 0 after each iteration.
- Reset, including mid-operation: next state ST_IDLE. Q_o=0, R_o=0, busy_o=0, done_o=0, div0_o=0. Internal registers and counter are cleared, and the aborted operation produces no done_o.

## Timing
- Start edge = edge 0 (the ST_IDLE edge where en_i=1).
- Normal divide:
  - busy_o is high from edge 0 to edge 8, i.e. 8 cycles.
  - Iterations occur on edges 1..8.
  - done_o is high, and Q_o/R_o are valid, between edge 8 and edge 9.
  - Back in ST_IDLE at edge 9.
  - Earliest next start is edge 10, so en_i held high restarts every 10 cycles.
- Divide-by-zero:
  - busy_o never asserts.
  - done_o and div0_o are high between edge 0 and edge 1.
  - Back in ST_IDLE at edge 1. Earliest next start is edge 2.
- done_o and busy_o are never high in the same cycle.
- A_i and B_i need only be valid at edge 0.

## Test plan
- Reset, then idle 5 cycles with en_i=0 -> all outputs 0, busy_o=0.
- Normal divides (A=200, B=7) and (A=255, B=15) at edge 0:
  - 200/7 -> busy_o for 8 cycles, then one-cycle done_o with Q_o=28, R_o=4, div0_o=0.
  - 255/15 -> Q_o=17, R_o=0.
- Boundary values:
  - A=5, B=9 -> Q_o=0, R_o=5.
  - A=0, B=1 -> Q_o=0, R_o=0.
  - A=255, B=1 -> Q_o=255, R_o=0.
- Divide-by-zero, A=13, B=0 -> done_o and div0_o high in the cycle after edge 0. Q_o=8'hFF, R_o=4'hF, busy_o never high. A following 100/10 -> Q_o=10, R_o=0, div0_o=0.
- Start 200/7, then pulse en_i with A=9, B=3 during ST_CALC -> ignored; result is still 28 r 4. Holding en_i high produces done_o every 10 cycles.
- Start 200/7, assert rst_i for one edge at edge 4 -> ST_IDLE, all outputs 0, no done_o. A new start 50/6 -> Q_o=8, R_o=2.
- Exhaustive: all 256x16 operand pairs -> A==Q*B+R and R<B for B!=0, div0_o for B==0.
